// File: rtl/pipeline_stream.sv
// Elastic valid/ready delay line: LENGTH register stages where stalls propagate
// upstream combinationally and empty stages (bubbles) are filled by upstream words.
module pipeline_stream #(
    parameter int LENGTH      = 2,
    parameter int WIDTH       = 1,
    parameter int COUNT_WIDTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [COUNT_WIDTH-1:0] count
);

    // Handshake: a word transfers on a rising edge only when valid and ready are
    // both high in the cycle before it; valid never waits on ready, ready may
    // depend combinationally on the opposite end.
    logic [LENGTH-1:0]      r_valid;
    logic [WIDTH-1:0]       r_data [LENGTH];
    logic [COUNT_WIDTH-1:0] r_count;
    logic [LENGTH-1:0]      w_mv;
    logic                   w_mv_chain;
    logic                   w_push;
    logic                   w_pop;

    // Walk from the output end back to the input so each stage sees whether its
    // downstream neighbour will make room this cycle.
    always_comb begin
        w_mv               = '0;
        w_mv_chain         = !r_valid[LENGTH-1] | out_ready;
        w_mv[LENGTH-1]     = w_mv_chain;
        for (int i = LENGTH - 2; i >= 0; i--) begin
            w_mv_chain = !r_valid[i] | (r_valid[i+1] ? w_mv_chain : 1'b1);
            w_mv[i]    = w_mv_chain;
        end
    end

    assign w_push = in_valid & w_mv[0];
    assign w_pop  = r_valid[LENGTH-1] & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            for (int i = 0; i < LENGTH; i++) begin
                r_data[i] <= '0;
            end
            r_count <= '0;
        end else begin
            if (w_mv[0]) begin
                r_valid[0] <= in_valid;
                if (in_valid) begin
                    r_data[0] <= in_data;
                end
            end
            for (int i = 1; i < LENGTH; i++) begin
                if (w_mv[i]) begin
                    r_valid[i] <= r_valid[i-1];
                    if (r_valid[i-1]) begin
                        r_data[i] <= r_data[i-1];
                    end
                end
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + COUNT_WIDTH'(1);
                2'b01:   r_count <= r_count - COUNT_WIDTH'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign in_ready  = w_mv[0];
    assign out_data  = r_data[LENGTH-1];
    assign out_valid = r_valid[LENGTH-1];
    assign count     = r_count;

endmodule

// File: doc/pipeline_stream.md
# pipeline_stream

Elastic, flow-controlled delay line carrying WIDTH-bit words through LENGTH register stages with a valid/ready handshake on both ends. It pairs with the free-running enable-gated pipeline. Here, stall information travels upstream: a consumer that deasserts ready stops the stream, bubbles between words collapse, and the producer is told when it must hold. It is used between the servo-command generator and the servo PWM channels on the hexapod, where the consumer may stall for an arbitrary number of cycles.

## Interface
- LENGTH, 2, number of register stages and maximum word capacity; must be at least 1.
- WIDTH, 1, data word width in bits.
- COUNT_WIDTH, 2, width of `count`; must be at least ceil(log2(LENGTH+1)).

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_data  in  WIDTH  word offered by the upstream producer.
- in_valid  in  1  `in_data` is valid this cycle.
- in_ready  out  1  block accepts `in_data` at the next edge; combinational.
- out_data  out  WIDTH  data of the last stage (LENGTH-1).
- out_valid  out  1  last stage holds a word.
- out_ready  in  1  downstream consumes `out_data` at the next edge.
- count  out  COUNT_WIDTH  number of words held, 0..LENGTH; registered.

## Operation
- State per stage i, for 0..LENGTH-1: `valid_q[i]` and `data_q[i]`. Stage 0 is the input end. Stage LENGTH-1 drives `out_data` and `out_valid`.
- Move conditions:
  - mv[LENGTH-1] = !valid_q[LENGTH-1] | out_ready
  - mv[i] = !valid_q[i] | (valid_q[i+1] ? mv[i+1] : 1), for i < LENGTH-1. A stage can take a word when it is empty or its occupant is leaving.
- in_ready = mv[0]. This is combinational from `out_ready` and the valid bits, with no register in the path.
- At the edge, for each stage i with mv[i] = 1:
  - i = 0: valid_q[0] <= in_valid, data_q[0] <= in_data.
  - i > 0: valid_q[i] <= valid_q[i-1], data_q[i] <= data_q[i-1].
- A stage with mv[i] = 0 holds its state.
- Stage data is only loaded when the stage moves. A word is never duplicated or dropped, and order is strictly FIFO.
- Bubble collapse: an empty stage downstream of a stalled word lets upstream words advance into it.
- push = in_valid & in_ready; pop = out_valid & out_ready. count <= count + push - pop. Simultaneous push and pop leave count unchanged.
- Reset: every `valid_q` = 0, every `data_q` = 0, count = 0. Outputs after reset: out_valid = 0, out_data = 0, count = 0, in_ready = 1.
- Reset overrides a push or pop in the same cycle. In-flight words are discarded and no partial state survives.
- `in_data` is ignored when in_valid = 0. No data is captured into a stage whose incoming valid bit is 0; the stage's data is merely don't-care.

## Timing
- Latency: a word pushed in cycle c appears on out_data with out_valid = 1 in cycle c+LENGTH, provided there is no stall.
- Throughput: one word per cycle sustained when out_ready = 1 continuously.
- Full (count = LENGTH): in_ready follows out_ready in the same cycle. When full with out_ready = 1, a push and a pop occur together and count stays at LENGTH.
- Stall: while out_ready = 0, out_data and out_valid are stable. A word reaches the last stage after LENGTH cycles if it is the oldest.
- LENGTH = 1: in_ready = !out_valid | out_ready. Behaves as a single registered stage.
- in_ready is valid in the same cycle as its inputs. The producer must not make in_valid depend combinationally on in_ready.

## Test plan
Parameters for all scenarios: LENGTH=3, WIDTH=8, COUNT_WIDTH=2.
- Reset: hold rst for 2 cycles with in_valid=1 -> out_valid=0, out_data=0x00, count=0, in_ready=1, and no word is captured.
- Streaming: push 0x01..0x08 on consecutive cycles with out_ready=1 -> 0x01 on the output 3 cycles after it was pushed, then one word per cycle in order; count holds at 3.
- Backpressure fill: out_ready=0, offer 0x10,0x11,0x12,0x13 -> first three accepted; in_ready drops after the third push; count=3; out_data=0x10 held stable.
- Drain with simultaneous push and pop: from the full state, raise out_ready while offering 0x13 -> in_ready=1 in the same cycle; output order 0x10,0x11,0x12,0x13; count stays 3 while both handshakes fire.
- Bubble collapse: out_ready=0, push 0xAA, wait 5 cycles, then push 0xBB -> 0xAA sits in stage 2 and 0xBB advances to stage 1 two cycles later; count=2; in_ready stays 1.
- Reset mid-operation: assert rst with count=2 and out_valid=1 -> the next cycle shows count=0 and out_valid=0; after release, a fresh push of 0x55 emerges alone after 3 cycles.
